seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one 8-bit segment bus (7 segments + dp) among NUM_DIGITS independent snake engines, one per digit.
- Owns the digit-select lines, ghosting-guard blanking and PWM brightness.
- Grants each engine a tear-free update window while its digit is blanked.
- Sits between the per-digit snake engines and the chip output pads.

---
 rtl/seg_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with ghosting blanking, PWM dimming and per-digit update grants.
// Optional macro SEG_ACTIVE_LOW_EN inverts seg_out/dig_sel for common-anode displays.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESC_W    = 12,
  parameter int BLANK_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [PRESC_W-1:0]      presc_div,
  input  logic [3:0]              duty,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   upd_req,
  output logic [NUM_DIGITS-1:0]   upd_gnt,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t             state_r, state_nx;
  logic [DW-1:0]      dig_r, dig_nx;
  logic [PRESC_W-1:0] cnt_r, cnt_nx;
  logic [PRESC_W-1:0] slot_len_r, slot_len_nx;
  logic [3:0]         pwm_r, pwm_nx;
  logic [7:0]         snap_r, snap_nx;
  logic               slot_start_s;
  logic [PRESC_W-1:0] presc_max_s;

  logic [7:0]            seg_nx;
  logic [NUM_DIGITS-1:0] sel_nx;
  logic [NUM_DIGITS-1:0] gnt_nx;
  logic                  fs_nx;

  assign presc_max_s = (presc_div > PRESC_W'(BLANK_CYC)) ? presc_div : PRESC_W'(BLANK_CYC);

  // State and registered outputs; outputs carry the value of the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dig_r       <= '0;
      cnt_r       <= '0;
      slot_len_r  <= '0;
      pwm_r       <= 4'd0;
      snap_r      <= 8'd0;
      upd_gnt     <= '0;
      seg_out     <= {8{INV}};
      dig_sel     <= {NUM_DIGITS{INV}};
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_nx;
      dig_r       <= dig_nx;
      cnt_r       <= cnt_nx;
      slot_len_r  <= slot_len_nx;
      pwm_r       <= pwm_nx;
      snap_r      <= snap_nx;
      upd_gnt     <= gnt_nx;
      seg_out     <= seg_nx ^ {8{INV}};
      dig_sel     <= sel_nx ^ {NUM_DIGITS{INV}};
      frame_start <= fs_nx;
    end
  end

  // Next-state: slot sequencing, digit advance, segment snapshot
  always_comb begin
    state_nx     = state_r;
    dig_nx       = dig_r;
    cnt_nx       = cnt_r;
    slot_len_nx  = slot_len_r;
    pwm_nx       = pwm_r;
    snap_nx      = snap_r;
    slot_start_s = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      dig_nx   = '0;
      cnt_nx   = '0;
      pwm_nx   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx     = BLANK;
          dig_nx       = '0;
          cnt_nx       = '0;
          slot_len_nx  = presc_max_s;
          slot_start_s = 1'b1;
        end
        BLANK: begin
          cnt_nx = cnt_r + PRESC_W'(1);
          if (cnt_r == PRESC_W'(BLANK_CYC - 1)) begin
            state_nx = DRIVE;
            pwm_nx   = 4'd0;
            snap_nx  = seg_in[int'(dig_r)*8 +: 8];
          end else begin
            state_nx = BLANK;
          end
        end
        DRIVE: begin
          if (cnt_r == slot_len_r) begin
            state_nx     = BLANK;
            cnt_nx       = '0;
            dig_nx       = (dig_r == DW'(NUM_DIGITS - 1)) ? DW'(0) : dig_r + DW'(1);
            slot_len_nx  = presc_max_s;
            slot_start_s = 1'b1;
          end else begin
            cnt_nx = cnt_r + PRESC_W'(1);
            pwm_nx = pwm_r + 4'd1;
          end
        end
        default: begin
          state_nx = IDLE;
          dig_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output decode for the state being entered; grant only on the first blank cycle of a slot
  always_comb begin
    seg_nx = 8'd0;
    sel_nx = '0;
    gnt_nx = '0;
    fs_nx  = 1'b0;
    if (state_nx == DRIVE) begin
      sel_nx = NUM_DIGITS'(1) << dig_nx;
      if ((duty == 4'hF) || (pwm_nx < duty)) begin
        seg_nx = snap_nx;
      end else begin
        seg_nx = 8'd0;
      end
    end else begin
      seg_nx = 8'd0;
      sel_nx = '0;
    end
    if (slot_start_s) begin
      fs_nx = (dig_nx == DW'(0));
      if (upd_req[dig_nx]) begin
        gnt_nx[dig_nx] = 1'b1;
      end else begin
        gnt_nx = '0;
      end
    end else begin
      fs_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (default active-high build, 4 digits, 4 blank cycles).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] presc_div = 12'd15;
  logic [3:0]  duty = 4'hF;
  logic [31:0] seg_in = 32'h4F5B063F;
  logic [3:0]  upd_req = 4'd0;
  logic [3:0]  upd_gnt;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_start;
  logic [16:0] obs;
  logic [16:0] exp_v;
  int          checks = 0;
  int          errors = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESC_W(12), .BLANK_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .presc_div(presc_div), .duty(duty),
    .seg_in(seg_in), .upd_req(upd_req), .upd_gnt(upd_gnt), .seg_out(seg_out),
    .dig_sel(dig_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  assign obs = {frame_start, upd_gnt, dig_sel, seg_out};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; upd_req = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Leaves the DUT in the first BLANK cycle of digit 0
  task automatic start_scan;
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 17'd0) begin
        errors++;
        $display("FAIL reset cyc%0d got %h want %h", i, obs, 17'd0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_slot;
    presc_div = 12'd15; duty = 4'hF; seg_in = 32'h4F5B063F;
    start_scan();
    for (int c = 0; c < 17; c++) begin
      if (c == 0)       exp_v = {1'b1, 4'd0, 4'd0, 8'd0};
      else if (c < 4)   exp_v = {1'b0, 4'd0, 4'd0, 8'd0};
      else if (c < 16)  exp_v = {1'b0, 4'd0, 4'b0001, 8'h3F};
      else              exp_v = {1'b0, 4'd0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL first_slot c%0d got %h want %h", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_frames;
    logic [7:0] b;
    do_reset();
    presc_div = 12'd15; duty = 4'hF; seg_in = 32'h4F5B063F;
    start_scan();
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 16; c++) begin
          b = seg_in[d*8 +: 8];
          exp_v = (c < 4) ? {(d == 0 && c == 0), 4'd0, 4'd0, 8'd0}
                          : {1'b0, 4'd0, 4'(1 << d), b};
          checks++;
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL frames f%0d d%0d c%0d got %h want %h", f, d, c, obs, exp_v);
          end
          tick();
        end
  endtask

  task automatic test_pwm;
    do_reset();
    presc_div = 12'd35; duty = 4'd4; seg_in = 32'h4F5B063F;
    start_scan();
    for (int c = 0; c < 36; c++) begin
      if (c < 4)                 exp_v = {1'b1 & (c == 0), 4'd0, 4'd0, 8'd0};
      else if (((c - 4) % 16) < 4) exp_v = {1'b0, 4'd0, 4'b0001, 8'h3F};
      else                       exp_v = {1'b0, 4'd0, 4'b0001, 8'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pwm c%0d got %h want %h", c, obs, exp_v);
      end
      tick();
    end
    // duty 0: digit lit, segments dark
    duty = 4'd0;
    for (int c = 0; c < 10; c++) tick();
    exp_v = {1'b0, 4'd0, 4'b0010, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pwm_duty0 got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_update;
    logic [7:0] b;
    do_reset();
    presc_div = 12'd15; duty = 4'hF; seg_in = 32'h4F5B063F;
    start_scan();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 16; c++) begin
          if (d == 2) b = (f == 0) ? 8'h41 : 8'h77;
          else        b = seg_in[d*8 +: 8];
          exp_v = (c < 4) ? {(d == 0 && c == 0), 4'(((f == 0) && (d == 2) && (c == 0)) ? 4'b0100 : 4'b0000), 4'd0, 8'd0}
                          : {1'b0, 4'd0, 4'(1 << d), b};
          checks++;
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL update f%0d d%0d c%0d got %h want %h", f, d, c, obs, exp_v);
          end
          if (f == 0 && d == 0 && c == 5) upd_req = 4'b0100;
          if (f == 0 && d == 2 && c == 0) begin
            upd_req = 4'd0;
            seg_in[23:16] = 8'h41;
          end
          if (f == 0 && d == 2 && c == 8) seg_in[23:16] = 8'h77;
          tick();
        end
  endtask

  task automatic test_disable;
    do_reset();
    presc_div = 12'd15; duty = 4'hF; seg_in = 32'h4F5B063F;
    start_scan();
    for (int i = 0; i < 23; i++) tick();
    exp_v = {1'b0, 4'd0, 4'b0010, 8'h06};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL disable_pre got %h want %h", obs, exp_v);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 17'd0) begin
        errors++;
        $display("FAIL disable_idle cyc%0d got %h want %h", i, obs, 17'd0);
      end
    end
    en = 1'b1;
    tick();
    exp_v = {1'b1, 4'd0, 4'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reenable_fs got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 4; i++) tick();
    exp_v = {1'b0, 4'd0, 4'b0001, 8'h3F};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reenable_d0 got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    presc_div = 12'd15; duty = 4'hF;
    start_scan();
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want %h", obs, 17'd0);
    end
    rst_n = 1'b1;
    tick();
    exp_v = {1'b1, 4'd0, 4'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_restart got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_short_slot;
    do_reset();
    presc_div = 12'd1; duty = 4'hF; seg_in = 32'h4F5B063F;
    start_scan();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 5; c++) begin
          exp_v = (c < 4) ? {(d == 0 && c == 0), 4'd0, 4'd0, 8'd0}
                          : {1'b0, 4'd0, 4'(1 << d), seg_in[d*8 +: 8]};
          checks++;
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL short_slot f%0d d%0d c%0d got %h want %h", f, d, c, obs, exp_v);
          end
          tick();
        end
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_frames();
    test_pwm();
    test_update();
    test_disable();
    test_reset_mid();
    test_short_slot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
